// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 field layout, constants, operand classes and divider states
// shared by fp16_div and fp16_mant_div.
// Optional feature macro: FP16_DIV_SUBNORMAL_EN (subnormal operands classified as ClsSub).
package fp16_pkg;

    localparam int unsigned SIGN_BIT = 15;
    localparam int unsigned EXP_MSB  = 14;
    localparam int unsigned EXP_LSB  = 10;
    localparam int unsigned MAN_MSB  = 9;

    localparam logic signed [6:0] BIAS    = 7'sd15;
    localparam logic signed [6:0] EXP_MIN = -7'sd14;
    localparam logic signed [6:0] EXP_MAX = 7'sd15;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;

    typedef enum logic [2:0] {
        ClsZero,
        ClsSub,
        ClsNorm,
        ClsInf,
        ClsNan
    } op_class_e;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StNorm,
        StDivide,
        StPostnorm,
        StRound,
        StPack
    } div_state_e;

    // Subnormals fold into zero unless subnormal support is built in
    function automatic op_class_e classify(input logic [15:0] x);
        logic [4:0] e;
        logic [9:0] m;
        e = x[EXP_MSB:EXP_LSB];
        m = x[MAN_MSB:0];
        if (e == 5'h1f) begin
            return (m != '0) ? ClsNan : ClsInf;
        end
        if (e != '0) begin
            return ClsNorm;
        end
`ifdef FP16_DIV_SUBNORMAL_EN
        return (m != '0) ? ClsSub : ClsZero;
`else
        return ClsZero;
`endif
    endfunction

`ifdef FP16_DIV_SUBNORMAL_EN
    // Left shift needed to bring the leading one of a nonzero mantissa to bit 10
    function automatic logic [3:0] lead_zeros(input logic [10:0] m);
        logic [3:0] n;
        n = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (m[i]) n = 4'(10 - i);
        end
        return n;
    endfunction
`endif

endpackage

// File: rtl/fp16_mant_div.sv
// fp16_mant_div: 14-cycle restoring radix-2 divider for 11-bit normalised mantissas.
// q[13] is the integer quotient bit; rem_nz reports a nonzero final remainder.
module fp16_mant_div
    import fp16_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] dividend,
    input  logic [10:0] divisor,
    output logic [13:0] q,
    output logic        rem_nz,
    output logic        valid
);

    logic [11:0] rem_q, rem_d;
    logic [10:0] dvs_q, dvs_d;
    logic [13:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        valid_q, valid_d;
    logic        ge;
    logic [11:0] rem_sub;

    // One compare/subtract/shift step per cycle while running
    always_comb begin
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        valid_d = valid_q;
        ge      = (rem_q >= {1'b0, dvs_q});
        rem_sub = ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
        if (start) begin
            rem_d   = {1'b0, dividend};
            dvs_d   = divisor;
            quo_d   = '0;
            cnt_d   = '0;
            run_d   = 1'b1;
            valid_d = 1'b0;
        end else if (run_q) begin
            rem_d = {rem_sub[10:0], 1'b0};
            quo_d = {quo_q[12:0], ge};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd13) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            valid_q <= valid_d;
        end
    end

    assign q      = quo_q;
    assign rem_nz = |rem_q;
    assign valid  = valid_q;

endmodule

// File: rtl/fp16_div.sv
// fp16_div: iterative binary16 divider, fixed 20-cycle latency, round-to-nearest-even.
// Optional feature macro: FP16_DIV_SUBNORMAL_EN (subnormal inputs and outputs);
// without it subnormal inputs read as zero and tiny results flush to zero.
module fp16_div
    import fp16_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [15:0] dataa,
    input  logic [15:0] datab,
    output logic [15:0] result,
    output logic        sign,
    output logic        overflow,
    output logic        underflow,
    output logic        nan,
    output logic        divzero,
    output logic        busy,
    output logic        done
);

    div_state_e state_q, state_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        sign_q, sign_d;
    op_class_e   cls_a_q, cls_a_d, cls_b_q, cls_b_d;
    logic signed [6:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d, e_q, e_d;
    logic [10:0] man_a_q, man_a_d, man_b_q, man_b_d, man_q, man_d;
    logic        guard_q, guard_d, sticky_q, sticky_d, flush_q, flush_d;
    logic [15:0] result_q, result_d;
    logic        overflow_q, overflow_d, underflow_q, underflow_d;
    logic        nan_q, nan_d, divzero_q, divzero_d, busy_q, busy_d, done_q, done_d;

    logic [10:0] norm_man_a, norm_man_b;
    logic signed [6:0] norm_exp_a, norm_exp_b;
    logic        div_start, div_rem_nz, div_valid;
    logic [13:0] div_q;

    logic signed [6:0] pn_e;
    logic [10:0] pn_man;
    logic        pn_g, pn_s, pn_flush;
`ifdef FP16_DIV_SUBNORMAL_EN
    logic signed [6:0] pn_diff;
    logic [3:0]  pn_sh;
    logic [11:0] pn_ext, pn_mask, pn_shifted;
`endif
    logic        rnd_up;
    logic [11:0] rnd_sum;
    logic [4:0]  pk_exp;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // Single-cycle normalisation of subnormal mantissas, used during NORM
    always_comb begin
        norm_man_a = man_a_q;
        norm_man_b = man_b_q;
        norm_exp_a = exp_a_q;
        norm_exp_b = exp_b_q;
`ifdef FP16_DIV_SUBNORMAL_EN
        if (cls_a_q == ClsSub) begin
            norm_man_a = man_a_q << lead_zeros(man_a_q);
            norm_exp_a = exp_a_q - $signed({3'b000, lead_zeros(man_a_q)});
        end
        if (cls_b_q == ClsSub) begin
            norm_man_b = man_b_q << lead_zeros(man_b_q);
            norm_exp_b = exp_b_q - $signed({3'b000, lead_zeros(man_b_q)});
        end
`endif
    end

    fp16_mant_div u_mant_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (norm_man_a),
        .divisor  (norm_man_b),
        .q        (div_q),
        .rem_nz   (div_rem_nz),
        .valid    (div_valid)
    );

    // Select mantissa/guard/sticky from the raw quotient and denormalise tiny results
    always_comb begin
        pn_e     = exp_a_q - exp_b_q;
        pn_flush = 1'b0;
        if (div_q[13]) begin
            pn_man = div_q[13:3];
            pn_g   = div_q[2];
            pn_s   = div_q[1] | div_q[0] | div_rem_nz;
        end else begin
            pn_man = div_q[12:2];
            pn_g   = div_q[1];
            pn_s   = div_q[0] | div_rem_nz;
            pn_e   = pn_e - 7'sd1;
        end
`ifdef FP16_DIV_SUBNORMAL_EN
        pn_diff    = EXP_MIN - pn_e;
        pn_sh      = (pn_diff > 7'sd12) ? 4'd12 : pn_diff[3:0];
        pn_ext     = {pn_man, pn_g};
        pn_mask    = ~(12'hfff << pn_sh);
        pn_shifted = pn_ext >> pn_sh;
        if (pn_e < EXP_MIN) begin
            pn_s   = pn_s | (|(pn_ext & pn_mask));
            pn_man = pn_shifted[11:1];
            pn_g   = pn_shifted[0];
            pn_e   = EXP_MIN;
        end
`else
        if (pn_e < EXP_MIN) pn_flush = 1'b1;
`endif
    end

    // Rounding increment and packed exponent field
    always_comb begin
        rnd_up  = guard_q & (sticky_q | man_q[0]);
        rnd_sum = {1'b0, man_q} + {11'd0, rnd_up};
        // e_q is within [-14, 15] whenever this field is used, so 5 bits suffice
        pk_exp  = e_q[4:0] + 5'd15;
        a_nan   = (cls_a_q == ClsNan);
        b_nan   = (cls_b_q == ClsNan);
        a_inf   = (cls_a_q == ClsInf);
        b_inf   = (cls_b_q == ClsInf);
        a_zero  = (cls_a_q == ClsZero);
        b_zero  = (cls_b_q == ClsZero);
    end

    // FSM next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        cls_a_d     = cls_a_q;
        cls_b_d     = cls_b_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        man_a_d     = man_a_q;
        man_b_d     = man_b_q;
        e_d         = e_q;
        man_d       = man_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        flush_d     = flush_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        nan_d       = nan_q;
        divzero_d   = divzero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clk_en) begin
                    a_d     = dataa;
                    b_d     = datab;
                    busy_d  = 1'b1;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                sign_d  = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
                cls_a_d = classify(a_q);
                cls_b_d = classify(b_q);
                exp_a_d = (a_q[EXP_MSB:EXP_LSB] == '0) ? EXP_MIN
                        : $signed({2'b00, a_q[EXP_MSB:EXP_LSB]}) - BIAS;
                exp_b_d = (b_q[EXP_MSB:EXP_LSB] == '0) ? EXP_MIN
                        : $signed({2'b00, b_q[EXP_MSB:EXP_LSB]}) - BIAS;
                man_a_d = {(a_q[EXP_MSB:EXP_LSB] != '0), a_q[MAN_MSB:0]};
                man_b_d = {(b_q[EXP_MSB:EXP_LSB] != '0), b_q[MAN_MSB:0]};
                state_d = StNorm;
            end
            StNorm: begin
                man_a_d   = norm_man_a;
                man_b_d   = norm_man_b;
                exp_a_d   = norm_exp_a;
                exp_b_d   = norm_exp_b;
                div_start = 1'b1;
                iter_d    = '0;
                state_d   = StDivide;
            end
            StDivide: begin
                if (iter_q == 4'd13) begin
                    state_d = StPostnorm;
                end else begin
                    iter_d = iter_q + 4'd1;
                end
            end
            StPostnorm: begin
                if (div_valid) begin
                    e_d      = pn_e;
                    man_d    = pn_man;
                    guard_d  = pn_g;
                    sticky_d = pn_s;
                    flush_d  = pn_flush;
                    state_d  = StRound;
                end
            end
            StRound: begin
                if (rnd_sum[11]) begin
                    man_d = rnd_sum[11:1];
                    e_d   = e_q + 7'sd1;
                end else begin
                    man_d = rnd_sum[10:0];
                end
                state_d = StPack;
            end
            StPack: begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
                nan_d       = 1'b0;
                divzero_d   = 1'b0;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = QNAN;
                    nan_d    = 1'b1;
                end else if (a_inf) begin
                    result_d = PINF | {sign_q, 15'd0};
                end else if (b_zero) begin
                    result_d  = PINF | {sign_q, 15'd0};
                    divzero_d = 1'b1;
                end else if (a_zero || b_inf) begin
                    result_d = {sign_q, 15'd0};
                end else if (e_q > EXP_MAX) begin
                    result_d   = PINF | {sign_q, 15'd0};
                    overflow_d = 1'b1;
                end else if (flush_q) begin
                    result_d    = {sign_q, 15'd0};
                    underflow_d = 1'b1;
                end else begin
                    result_d    = {sign_q, (man_q[10] ? pk_exp : 5'd0), man_q[9:0]};
                    underflow_d = ~man_q[10];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // All FSM, datapath and output registers; reset aborts any operation
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            iter_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            cls_a_q     <= ClsZero;
            cls_b_q     <= ClsZero;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            man_a_q     <= '0;
            man_b_q     <= '0;
            e_q         <= '0;
            man_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            flush_q     <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            nan_q       <= 1'b0;
            divzero_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            cls_a_q     <= cls_a_d;
            cls_b_q     <= cls_b_d;
            exp_a_q     <= exp_a_d;
            exp_b_q     <= exp_b_d;
            man_a_q     <= man_a_d;
            man_b_q     <= man_b_d;
            e_q         <= e_d;
            man_q       <= man_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            flush_q     <= flush_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            nan_q       <= nan_d;
            divzero_q   <= divzero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign result    = result_q;
    assign sign      = result_q[SIGN_BIT];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign nan       = nan_q;
    assign divzero   = divzero_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fp16_div.sv
// tb_fp16_div: directed and randomized checks of fp16_div against an exact-arithmetic
// reference model. Honours FP16_DIV_SUBNORMAL_EN like the design.
module tb_fp16_div;

`ifdef FP16_DIV_SUBNORMAL_EN
    localparam bit SUB = 1'b1;
    localparam logic [19:0] TINY_EXP = {16'h0200, 4'b0100};
`else
    localparam bit SUB = 1'b0;
    localparam logic [19:0] TINY_EXP = {16'h0000, 4'b0100};
`endif

    logic        clock = 1'b0;
    logic        reset, clk_en;
    logic [15:0] dataa, datab, result;
    logic        sign, overflow, underflow, nan, divzero, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    fp16_div dut (
        .clock     (clock),
        .reset     (reset),
        .clk_en    (clk_en),
        .dataa     (dataa),
        .datab     (datab),
        .result    (result),
        .sign      (sign),
        .overflow  (overflow),
        .underflow (underflow),
        .nan       (nan),
        .divzero   (divzero),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact quotient Ma/Mb * 2^(Ea-Eb), rounded to nearest-even at the result's LSB weight.
    // Returns {result, overflow, underflow, nan, divzero}.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
        int fa, fb, ma, mb, ea, eb, e, lsb, t;
        longint num, den, n, r;
        bit s, a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        fa = int'(a[14:10]);
        fb = int'(b[14:10]);
        ma = int'(a[9:0]);
        mb = int'(b[9:0]);
        s  = a[15] ^ b[15];
        a_nan  = (fa == 31) && (ma != 0);
        a_inf  = (fa == 31) && (ma == 0);
        a_zero = (fa == 0) && ((ma == 0) || !SUB);
        b_nan  = (fb == 31) && (mb != 0);
        b_inf  = (fb == 31) && (mb == 0);
        b_zero = (fb == 0) && ((mb == 0) || !SUB);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {16'h7E00, 4'b0010};
        if (a_inf) return {s, 15'h7C00, 4'b0000};
        if (b_zero) return {s, 15'h7C00, 4'b0001};
        if (a_zero || b_inf) return {s, 15'h0000, 4'b0000};
        ea = (fa == 0) ? -14 : fa - 15;
        eb = (fb == 0) ? -14 : fb - 15;
        if (fa != 0) ma += 1024;
        if (fb != 0) mb += 1024;
        while (ma < 1024) begin ma *= 2; ea--; end
        while (mb < 1024) begin mb *= 2; eb--; end
        e = ea - eb - ((ma < mb) ? 1 : 0);
        if (!SUB && e < -14) return {s, 15'h0000, 4'b0100};
        lsb = ((e < -14) ? -14 : e) - 10;
        t   = ea - eb - lsb;
        num = longint'(ma);
        den = longint'(mb);
        if (t >= 0) num = num << t;
        else        den = den << (-t);
        n = num / den;
        r = num % den;
        if ((2 * r > den) || ((2 * r == den) && (n % 2 == 1))) n++;
        if (n == 2048) begin n = 1024; lsb++; end
        if (n >= 1024) begin
            if (lsb + 10 > 15) return {s, 15'h7C00, 4'b1000};
            return {s, 5'(lsb + 25), 10'(n), 4'b0000};
        end
        return {s, 5'd0, 10'(n), 4'b0100};
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 6))
            0: v[14:10] = 5'd0;
            1: v[14:10] = 5'd31;
            2: v[14:10] = 5'($urandom_range(1, 3));
            3: v[14:10] = 5'($urandom_range(27, 30));
            4: v[9:0] = '0;
            default: ;
        endcase
        return v;
    endfunction

    // Caller sits at a negedge; issues one op and checks latency, busy and outputs
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [19:0] exp);
        int cyc;
        bit busy_ok;
        string tag;
        tag = $sformatf("%h/%h", a, b);
        dataa   = a;
        datab   = b;
        clk_en  = 1'b1;
        cyc     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) clk_en = 1'b0;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && cyc < 30);
        check_eq({tag, " latency"}, 32'(cyc), 32'd20);
        check_eq({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check_eq({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " out"}, {12'd0, result, overflow, underflow, nan, divzero}, {12'd0, exp});
        check_eq({tag, " sign"}, {31'd0, sign}, {31'd0, exp[19]});
    endtask

    logic [15:0] dir_a [8] = '{16'h4000, 16'h3C00, 16'hC000, 16'h3C00,
                               16'h0000, 16'h7C00, 16'h7BFF, 16'h0400};
    logic [15:0] dir_b [8] = '{16'h3C00, 16'h4200, 16'h4000, 16'h0000,
                               16'h0000, 16'h7C00, 16'h0400, 16'h4000};
    logic [19:0] dir_e [8] = '{{16'h4000, 4'b0000}, {16'h3555, 4'b0000},
                               {16'hBC00, 4'b0000}, {16'h7C00, 4'b0001},
                               {16'h7E00, 4'b0010}, {16'h7E00, 4'b0010},
                               {16'h7C00, 4'b1000}, TINY_EXP};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done, d1, d2;
        logic [15:0] r1, r2, a, b;
        reset  = 1'b1;
        clk_en = 1'b1;
        dataa  = 16'h4000;
        datab  = 16'h3C00;
        repeat (3) @(negedge clock);
        check_eq("reset_outputs", {10'd0, result, overflow, underflow, nan, divzero, busy, done},
                 32'd0);
        reset  = 1'b0;
        clk_en = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) run_op(dir_a[i], dir_b[i], dir_e[i]);

        for (int i = 0; i < 250; i++) begin
            a = rnd_op();
            b = rnd_op();
            run_op(a, b, model(a, b));
        end

        // clk_en held high: one op per 20 cycles, new op accepted in the done cycle
        dataa  = 16'h3C00;
        datab  = 16'h4200;
        clk_en = 1'b1;
        n_done = 0;
        d1 = 0; d2 = 0; r1 = '0; r2 = '0;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clock);
            if (done) begin
                n_done++;
                if (n_done == 1) begin d1 = c; r1 = result; end
                if (n_done == 2) begin d2 = c; r2 = result; end
            end
            if (c == 10) begin dataa = 16'hC000; datab = 16'h4000; end
        end
        check_eq("held_done_count", 32'(n_done), 32'd2);
        check_eq("held_done1_cycle", 32'(d1), 32'd20);
        check_eq("held_done2_cycle", 32'(d2), 32'd40);
        check_eq("held_result1", {16'd0, r1}, 32'h3555);
        check_eq("held_result2", {16'd0, r2}, 32'hBC00);
        check_eq("third_op_busy", {31'd0, busy}, 32'd1);

        // Reset eight cycles into the third operation, clk_en still high
        reset = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        clk_en = 1'b0;
        check_eq("abort_outputs", {10'd0, result, overflow, underflow, nan, divzero, busy, done},
                 32'd0);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (done || busy) n_done++;
        end
        check_eq("abort_no_done", 32'(n_done), 32'd0);
        run_op(16'h4000, 16'h3C00, {16'h4000, 4'b0000});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
